// File: rtl/rc4_pkg.sv
// Shared types for the RC4 key-search result path.
//   arb_state_t : arbiter FSM state (IDLE, SEARCH, FOUND, EXHAUSTED)
//   MSG_LEN     : plaintext length in bytes
//   msg_t       : MSG_LEN x 8-bit plaintext, packed so it maps onto a flat bus
package rc4_pkg;

  localparam int MSG_LEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEARCH    = 2'd1,
    ST_FOUND     = 2'd2,
    ST_EXHAUSTED = 2'd3
  } arb_state_t;

  typedef logic [MSG_LEN-1:0][7:0] msg_t;

endpackage

// File: rtl/core_result_arbiter_priority_select.sv
// priority_select: combinational lowest-index-wins encoder.
//   req_i    : request vector
//   any_o    : at least one request present
//   onehot_o : one-hot mask of the winning (lowest-index) request
//   idx_o    : binary index of the winning request (0 when none)
module priority_select #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  output logic             any_o,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the top down so the last hit, i.e. the lowest index, wins.
  always_comb begin
    any_o    = |req_i;
    onehot_o = '0;
    idx_o    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/core_result_arbiter.sv
// core_result_arbiter: collects found/done pulses from CORES parallel
// decryption cores, latches the first (lowest-index) winner, or flags the
// key space as exhausted once every core has reported done.
//   CLOCK_50, reset_n      : clock, async active-low reset
//   start                  : pulse, starts a search (ignored while searching)
//   core_found/core_done   : per-core pulses
//   core_key/core_data     : per-core key and plaintext, flat buses, core 0 in the LSBs
//   stop_cores, busy       : freeze level to cores / search in progress
//   result_valid, secret_key, decrypted_data, winner_idx : captured winner
//   LED_GOOD, LED_BAD      : key found / key space exhausted or timed out
//   state_dbg_o            : current FSM state (arb_state_t encoding)
//   timed_out              : only with ARB_TIMEOUT_EN; watchdog fired
// Optional feature macro: ARB_TIMEOUT_EN adds a search watchdog of
// TIMEOUT_CYCLES cycles and the timed_out port.
module core_result_arbiter
  import rc4_pkg::*;
#(
  parameter int CORES          = 4,
  parameter int KEY_W          = 24,
  parameter int TIMEOUT_CYCLES = 1 << 26,
  localparam int IDX_W         = (CORES > 1) ? $clog2(CORES) : 1
) (
  input  logic                       CLOCK_50,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [CORES-1:0]           core_found,
  input  logic [CORES-1:0]           core_done,
  input  logic [CORES*KEY_W-1:0]     core_key,
  input  logic [CORES*MSG_LEN*8-1:0] core_data,
  output logic                       stop_cores,
  output logic                       busy,
  output logic                       result_valid,
  output logic [KEY_W-1:0]           secret_key,
  output logic [MSG_LEN*8-1:0]       decrypted_data,
  output logic [IDX_W-1:0]           winner_idx,
  output logic                       LED_GOOD,
  output logic                       LED_BAD,
`ifdef ARB_TIMEOUT_EN
  output logic                       timed_out,
`endif
  output logic [1:0]                 state_dbg_o
);

  arb_state_t         state_q;
  logic [CORES-1:0]   done_mask_q;
  logic               stop_q, busy_q, valid_q, good_q, bad_q;
  logic [KEY_W-1:0]   key_q;
  msg_t               data_q;
  logic [IDX_W-1:0]   idx_q;

  logic               found_any;
  logic [CORES-1:0]   sel_onehot_unused;
  logic [IDX_W-1:0]   sel_idx;
  logic               all_done;

  priority_select #(.N(CORES), .IDX_W(IDX_W)) u_sel (
    .req_i    (core_found),
    .any_o    (found_any),
    .onehot_o (sel_onehot_unused),
    .idx_o    (sel_idx)
  );

  // This cycle's done pulses count toward exhaustion immediately.
  assign all_done = &(done_mask_q | core_done);

`ifdef ARB_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;
  logic        tmo_q;
  logic        tmo_hit;
  assign tmo_hit = (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      done_mask_q <= '0;
      stop_q      <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
      key_q       <= '0;
      data_q      <= '0;
      idx_q       <= '0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_SEARCH: begin
          done_mask_q <= done_mask_q | core_done;
`ifdef ARB_TIMEOUT_EN
          tmo_cnt_q   <= tmo_cnt_q + 32'd1;
`endif
          // Found beats done: a core may report done and later found.
          if (found_any) begin
            state_q <= ST_FOUND;
            key_q   <= core_key[int'(sel_idx)*KEY_W +: KEY_W];
            data_q  <= core_data[int'(sel_idx)*MSG_LEN*8 +: MSG_LEN*8];
            idx_q   <= sel_idx;
            valid_q <= 1'b1;
            good_q  <= 1'b1;
            stop_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (all_done) begin
            state_q <= ST_EXHAUSTED;
            bad_q   <= 1'b1;
            stop_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (tmo_hit) begin
            state_q <= ST_EXHAUSTED;
            bad_q   <= 1'b1;
            stop_q  <= 1'b1;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b1;
          end
`endif
        end
        default: begin
          // IDLE, FOUND, EXHAUSTED: only start matters; the previous key,
          // data and index stay on the outputs but result_valid drops.
          if (start) begin
            state_q     <= ST_SEARCH;
            done_mask_q <= '0;
            stop_q      <= 1'b0;
            busy_q      <= 1'b1;
            valid_q     <= 1'b0;
            good_q      <= 1'b0;
            bad_q       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            tmo_q       <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

  assign stop_cores     = stop_q;
  assign busy           = busy_q;
  assign result_valid   = valid_q;
  assign secret_key     = key_q;
  assign decrypted_data = data_q;
  assign winner_idx     = idx_q;
  assign LED_GOOD       = good_q;
  assign LED_BAD        = bad_q;
  assign state_dbg_o    = state_q;
`ifdef ARB_TIMEOUT_EN
  assign timed_out      = tmo_q;
`endif

endmodule

// File: tb/tb_core_result_arbiter.sv
// Bench for core_result_arbiter: directed and random searches, a reference
// model that replays each search cycle by cycle to predict the outcome and
// the cycle it becomes visible, and a monitor that pops predictions when the
// DUT raises result_valid or LED_BAD.
module tb_core_result_arbiter;

  localparam int CORES = 4;
  localparam int KEY_W = 24;
  localparam int IDX_W = 2;
  localparam int DW    = 256;
  localparam int W     = 32 + 3 + IDX_W + KEY_W + DW;
  localparam int MAXL  = 64;

  logic                   clk, rst_n, start;
  logic [CORES-1:0]       core_found, core_done;
  logic [CORES*KEY_W-1:0] core_key;
  logic [CORES*DW-1:0]    core_data;
  logic                   stop_cores, busy, result_valid, LED_GOOD, LED_BAD;
  logic [KEY_W-1:0]       secret_key;
  logic [DW-1:0]          decrypted_data;
  logic [IDX_W-1:0]       winner_idx;
  logic [1:0]             state_dbg;
  logic                   to_obs;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  core_result_arbiter #(.CORES(CORES), .KEY_W(KEY_W), .TIMEOUT_CYCLES(100)) dut (
    .CLOCK_50       (clk),
    .reset_n        (rst_n),
    .start          (start),
    .core_found     (core_found),
    .core_done      (core_done),
    .core_key       (core_key),
    .core_data      (core_data),
    .stop_cores     (stop_cores),
    .busy           (busy),
    .result_valid   (result_valid),
    .secret_key     (secret_key),
    .decrypted_data (decrypted_data),
    .winner_idx     (winner_idx),
    .LED_GOOD       (LED_GOOD),
    .LED_BAD        (LED_BAD),
`ifdef ARB_TIMEOUT_EN
    .timed_out      (to_obs),
`endif
    .state_dbg_o    (state_dbg)
  );

`ifndef ARB_TIMEOUT_EN
  assign to_obs = 1'b0;
`endif

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input int c, input logic g, input logic b, input logic t,
                                        input logic [IDX_W-1:0] i, input logic [KEY_W-1:0] k,
                                        input logic [DW-1:0] d);
    return {32'(c), g, b, t, i, k, d};
  endfunction

  // stimulus tables for one search
  logic [CORES-1:0]       f_seq[MAXL];
  logic [CORES-1:0]       d_seq[MAXL];
  logic [CORES*KEY_W-1:0] k_seq[MAXL];
  logic [CORES*DW-1:0]    dat_seq[MAXL];
  logic                   st_seq[MAXL];
  int                     seq_len;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk the search; the first cycle with any found bit wins
  // (lowest core), otherwise the first cycle by which every core has been
  // seen done exhausts. Outcome visible one cycle after that table row.
  task automatic model(input int c0, output int dec);
    logic [CORES-1:0] seen;
    int w;
    seen = '0;
    dec  = -1;
    for (int k = 0; k < seq_len; k++) begin
      if (f_seq[k] != '0) begin
        w = 0;
        for (int i = CORES - 1; i >= 0; i--) if (f_seq[k][i]) w = i;
        exp_q.push_back(pack(c0 + k + 1, 1'b1, 1'b0, 1'b0, IDX_W'(w),
                             k_seq[k][w*KEY_W +: KEY_W], dat_seq[k][w*DW +: DW]));
        dec = k;
        return;
      end
      seen = seen | d_seq[k];
      if (seen == {CORES{1'b1}}) begin
        exp_q.push_back(pack(c0 + k + 1, 1'b0, 1'b1, 1'b0, '0, '0, '0));
        dec = k;
        return;
      end
    end
  endtask

  task automatic rand_row(input int k);
    for (int j = 0; j < CORES; j++) k_seq[k][j*KEY_W +: KEY_W] = KEY_W'($urandom);
    for (int j = 0; j < CORES * DW / 32; j++) dat_seq[k][j*32 +: 32] = $urandom;
    f_seq[k]  = '0;
    d_seq[k]  = '0;
    st_seq[k] = 1'b0;
  endtask

  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      core_found = CORES'($urandom);
      core_done  = CORES'($urandom);
      core_key   = {CORES{KEY_W'($urandom)}};
      step();
    end
    core_found = '0;
    core_done  = '0;
  endtask

  // driver: pulse start, then play the table one row per cycle
  task automatic run_seq();
    int c0, dec;
    start = 1'b1;
    core_found = '0;
    core_done  = '0;
    step();
    start = 1'b0;
    c0 = cyc;
    chk("busy_after_start", busy, 1'b1);
    model(c0, dec);
    // A start after the decision would legitimately begin a new search.
    for (int k = dec + 1; k < seq_len; k++) st_seq[k] = 1'b0;
    for (int k = 0; k < seq_len; k++) begin
      core_found = f_seq[k];
      core_done  = d_seq[k];
      core_key   = k_seq[k];
      core_data  = dat_seq[k];
      start      = st_seq[k];
      step();
    end
    start = 1'b0;
    idle_noise(3);
  endtask

  function automatic logic [W-1:0] all_outs();
    return W'({stop_cores, busy, result_valid, LED_GOOD, LED_BAD, to_obs,
               winner_idx, secret_key, decrypted_data, state_dbg});
  endfunction

  // monitor
  logic prev_ev = 1'b0;
  logic prev_rv = 1'b0;
  logic [IDX_W+KEY_W+DW-1:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ev <= 1'b0;
      prev_rv <= 1'b0;
    end else begin
      chk("led_exclusive", W'(LED_GOOD & LED_BAD), '0);
      chk("stop_cores_level", W'(stop_cores), W'(result_valid | LED_BAD));
      if (result_valid && prev_rv)
        chk("result_hold", W'({winner_idx, secret_key, decrypted_data}), W'(held));
      if ((result_valid | LED_BAD) && !prev_ev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_outcome: good=%0b bad=%0b idx=%0d at cycle %0d, none expected",
                   LED_GOOD, LED_BAD, winner_idx, cyc);
        end else begin
          chk("outcome", pack(cyc, LED_GOOD, LED_BAD, to_obs,
                              LED_BAD ? '0 : winner_idx,
                              LED_BAD ? '0 : secret_key,
                              LED_BAD ? '0 : decrypted_data), exp_q.pop_front());
          chk("busy_low_on_outcome", W'(busy), '0);
        end
      end
      prev_ev <= result_valid | LED_BAD;
      prev_rv <= result_valid;
      held    <= {winner_idx, secret_key, decrypted_data};
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    core_found = '0;
    core_done  = '0;
    core_key   = '0;
    core_data  = '0;
    repeat (3) step();
    chk("reset_outputs", all_outs(), '0);
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", all_outs(), '0);

    // single winner on core 2
    seq_len = 1; rand_row(0);
    f_seq[0] = 4'b0100; k_seq[0][2*KEY_W +: KEY_W] = 24'h000249;
    run_seq();

    // two simultaneous winners, lowest index takes it
    seq_len = 1; rand_row(0);
    f_seq[0] = 4'b1010;
    k_seq[0][1*KEY_W +: KEY_W] = 24'd11;
    k_seq[0][3*KEY_W +: KEY_W] = 24'd33;
    run_seq();

    // done pulses on each core in turn -> exhausted
    seq_len = 4;
    for (int k = 0; k < 4; k++) begin rand_row(k); d_seq[k] = 4'(1 << k); end
    run_seq();

    // last done and a found in the same cycle -> found
    seq_len = 1; rand_row(0);
    d_seq[0] = 4'b1111; f_seq[0] = 4'b1000;
    run_seq();

    // core reports done, later found; start in mid-search ignored
    seq_len = 3;
    for (int k = 0; k < 3; k++) rand_row(k);
    d_seq[0] = 4'b0001; st_seq[1] = 1'b1; f_seq[2] = 4'b0001;
    run_seq();

    // reset in the middle of a search
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", all_outs(), '0);
    step();
    rst_n = 1'b1;
    step();
    core_found = 4'b0001; core_key = {CORES{24'h123456}};
    step();
    core_found = '0;
    step();
    chk("found_ignored_after_reset", all_outs(), '0);
    seq_len = 1; rand_row(0); f_seq[0] = 4'b0001;
    run_seq();

    // random searches, always closed by a final all-done row
    for (int s = 0; s < 40; s++) begin
      seq_len = $urandom_range(3, 16);
      for (int k = 0; k < seq_len; k++) begin
        rand_row(k);
        if ($urandom_range(0, 5) == 0) f_seq[k] = CORES'($urandom);
        d_seq[k] = CORES'($urandom & $urandom);
        if (k > 0 && $urandom_range(0, 7) == 0) st_seq[k] = 1'b1;
      end
      d_seq[seq_len-1] = '1;
      run_seq();
      idle_noise($urandom_range(0, 4));
    end

`ifdef ARB_TIMEOUT_EN
    // no activity: watchdog fires 100 cycles after start
    begin
      int c0;
      start = 1'b1; step(); start = 1'b0;
      c0 = cyc;
      exp_q.push_back(pack(c0 + 100, 1'b0, 1'b1, 1'b1, '0, '0, '0));
      repeat (105) step();
      chk("timed_out_level", W'(to_obs), W'(1));
    end
`endif

    repeat (3) step();
    chk("queue_drained", W'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
